// File: rtl/fb_pixel_plotter.sv
// fb_pixel_plotter
//   Plots single pixels into a packed framebuffer held in word memory. Each
//   pixel becomes a read-modify-write of the 32-bit word that holds it. A
//   one-word write-combining buffer merges pixels that land in the same word,
//   so consecutive hits cost no memory traffic.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     pixel command handshake
//   in_x, in_y            signed pixel coordinates (COORD_W bits)
//   in_color, in_mode     colour (low BPP bits) and raster op (OR/REPLACE/XOR/CLEAR)
//   flush_req/flush_done  write back and invalidate the buffer / completion pulse
//   mem_req_*             request port (we=1 write, we=0 read), held until ready
//   mem_rsp_valid/rdata   read response
//   busy                  FSM not idle, or the buffer holds unwritten data
//   plot_count            saturating count of pixels plotted
//   clip_count            saturating count of pixels dropped as off-screen
module fb_pixel_plotter #(
  parameter int          FB_WIDTH  = 64,
  parameter int          FB_HEIGHT = 64,
  parameter int          BPP       = 1,
  parameter logic [31:0] FB_BASE   = 32'h2000,
  parameter int          COORD_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] in_x,
  input  logic signed [COORD_W-1:0] in_y,
  input  logic [7:0]                in_color,
  input  logic [1:0]                in_mode,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [31:0]               mem_req_addr,
  output logic [31:0]               mem_req_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [31:0]               mem_rsp_rdata,
  output logic                      busy,
  output logic [15:0]               plot_count,
  output logic [15:0]               clip_count
);

  localparam int PPW     = 32 / BPP;
  localparam int WPR     = FB_WIDTH / PPW;
  localparam int PPW_LOG = $clog2(PPW);
  localparam int BPP_LOG = $clog2(BPP);
  localparam logic [31:0] WPR_W      = 32'(WPR);
  localparam logic [31:0] FIELD_MASK = 32'((64'd1 << BPP) - 64'd1);
  localparam logic signed [COORD_W-1:0] W_LIM = COORD_W'(FB_WIDTH);
  localparam logic signed [COORD_W-1:0] H_LIM = COORD_W'(FB_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_RWAIT} state_t;

  // Apply the raster op to the BPP-wide field at bit offset sh of word w.
  function automatic logic [31:0] apply_op(input logic [31:0] w, input logic [4:0] sh,
                                           input logic [7:0] c, input logic [1:0] m);
    logic [31:0] mask;
    logic [31:0] cf;
    logic [31:0] res;
    mask = FIELD_MASK << sh;
    cf   = ({24'd0, c} & FIELD_MASK) << sh;
    case (m)
      2'b00:   res = w | cf;
      2'b01:   res = (w & ~mask) | cf;
      2'b10:   res = w ^ cf;
      default: res = w & ~mask;
    endcase
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic        buf_dirty_q, buf_dirty_d;
  logic        flush_pend_q, flush_pend_d;
  logic        flush_done_q, flush_done_d;
  logic [15:0] plot_q, plot_d;
  logic [15:0] clip_q, clip_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [4:0]  pend_sh_q, pend_sh_d;
  logic [7:0]  pend_color_q, pend_color_d;
  logic [1:0]  pend_mode_q, pend_mode_d;

  logic        idle_ready;
  logic        in_range;
  logic        hit;
  logic [31:0] x_u;
  logic [31:0] y_u;
  logic [31:0] pix_addr;
  logic [4:0]  pix_sh;

  // Pixel address decode; only meaningful once the coordinates are known non-negative.
  always_comb begin
    x_u      = 32'($unsigned(in_x));
    y_u      = 32'($unsigned(in_y));
    in_range = !in_x[COORD_W-1] && !in_y[COORD_W-1] && (in_x < W_LIM) && (in_y < H_LIM);
    pix_addr = FB_BASE + ((y_u * WPR_W + (x_u >> PPW_LOG)) << 2);
    // (x % PPW) * BPP equals (x * BPP) % 32 because PPW * BPP == 32.
    pix_sh   = 5'(x_u[4:0] << BPP_LOG);
    hit      = buf_valid_q && (pix_addr == buf_addr_q);
  end

  assign idle_ready = (state_q == S_IDLE) && !flush_req;

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      buf_valid_q  <= 1'b0;
      buf_dirty_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      plot_q       <= 16'd0;
      clip_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_dirty_q  <= buf_dirty_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      plot_q       <= plot_d;
      clip_q       <= clip_d;
    end
  end

  // Buffer and pending-pixel data; qualified by the control bits, so no reset
  always_ff @(posedge clk) begin
    buf_addr_q   <= buf_addr_d;
    buf_data_q   <= buf_data_d;
    pend_addr_q  <= pend_addr_d;
    pend_sh_q    <= pend_sh_d;
    pend_color_q <= pend_color_d;
    pend_mode_q  <= pend_mode_d;
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_dirty_d  = buf_dirty_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
    plot_d       = plot_q;
    clip_d       = clip_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    pend_addr_d  = pend_addr_q;
    pend_sh_d    = pend_sh_q;
    pend_color_d = pend_color_q;
    pend_mode_d  = pend_mode_q;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          // Invalidate now so later external writes to this word are re-read.
          buf_valid_d = 1'b0;
          if (buf_dirty_q) begin
            flush_pend_d = 1'b1;
            state_d      = S_WB;
          end else begin
            flush_done_d = 1'b1;
          end
        end else if (in_valid) begin
          if (!in_range) begin
            clip_d = sat_inc(clip_q);
          end else if (hit) begin
            buf_data_d  = apply_op(buf_data_q, pix_sh, in_color, in_mode);
            buf_dirty_d = 1'b1;
            plot_d      = sat_inc(plot_q);
          end else begin
            pend_addr_d  = pix_addr;
            pend_sh_d    = pix_sh;
            pend_color_d = in_color;
            pend_mode_d  = in_mode;
            flush_pend_d = 1'b0;
            state_d      = buf_dirty_q ? S_WB : S_RD;
          end
        end
      end
      S_WB: begin
        if (mem_req_ready) begin
          buf_dirty_d = 1'b0;
          if (flush_pend_q) begin
            flush_pend_d = 1'b0;
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_req_ready) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (mem_rsp_valid) begin
          buf_data_d  = apply_op(mem_rsp_rdata, pend_sh_q, pend_color_q, pend_mode_q);
          buf_addr_d  = pend_addr_q;
          buf_valid_d = 1'b1;
          buf_dirty_d = 1'b1;
          plot_d      = sat_inc(plot_q);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the request fields are zero whenever no request is offered
  always_comb begin
    in_ready      = idle_ready;
    mem_req_valid = (state_q == S_WB) || (state_q == S_RD);
    mem_req_we    = (state_q == S_WB);
    mem_req_addr  = 32'd0;
    mem_req_wdata = 32'd0;
    if (state_q == S_WB) begin
      mem_req_addr  = buf_addr_q;
      mem_req_wdata = buf_data_q;
    end else if (state_q == S_RD) begin
      mem_req_addr = pend_addr_q;
    end
    busy       = (state_q != S_IDLE) || buf_dirty_q;
    flush_done = flush_done_q;
    plot_count = plot_q;
    clip_count = clip_q;
  end

endmodule

// File: tb/tb_fb_pixel_plotter.sv
// Bench for fb_pixel_plotter: instance 0 uses BPP=1, instance 1 uses BPP=4,
// both 64x64 at 0x2000. A memory model answers reads one cycle after the
// request handshake; every handshake is logged and compared in order against
// a queue of expected requests filled when the stimulus is driven.
module tb_fb_pixel_plotter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int          x;
    int          y;
    logic [7:0]  c;
    logic [1:0]  m;
    logic [31:0] rd;
    logic        clip;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst           [2];
  logic               in_valid      [2];
  logic               in_ready      [2];
  logic signed [15:0] in_x          [2];
  logic signed [15:0] in_y          [2];
  logic [7:0]         in_color      [2];
  logic [1:0]         in_mode       [2];
  logic               flush_req     [2];
  logic               flush_done    [2];
  logic               mem_req_valid [2];
  logic               mem_req_ready [2];
  logic               mem_req_we    [2];
  logic [31:0]        mem_req_addr  [2];
  logic [31:0]        mem_req_wdata [2];
  logic               mem_rsp_valid [2] = '{1'b0, 1'b0};
  logic [31:0]        mem_rsp_rdata [2] = '{32'd0, 32'd0};
  logic               busy          [2];
  logic [15:0]        plot_count    [2];
  logic [15:0]        clip_count    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fb_pixel_plotter #(
      .FB_WIDTH (64),
      .FB_HEIGHT(64),
      .BPP      ((g == 0) ? 1 : 4),
      .FB_BASE  (32'h2000),
      .COORD_W  (16)
    ) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .in_x         (in_x[g]),
      .in_y         (in_y[g]),
      .in_color     (in_color[g]),
      .in_mode      (in_mode[g]),
      .flush_req    (flush_req[g]),
      .flush_done   (flush_done[g]),
      .mem_req_valid(mem_req_valid[g]),
      .mem_req_ready(mem_req_ready[g]),
      .mem_req_we   (mem_req_we[g]),
      .mem_req_addr (mem_req_addr[g]),
      .mem_req_wdata(mem_req_wdata[g]),
      .mem_rsp_valid(mem_rsp_valid[g]),
      .mem_rsp_rdata(mem_rsp_rdata[g]),
      .busy         (busy[g]),
      .plot_count   (plot_count[g]),
      .clip_count   (clip_count[g])
    );
  end

  // Request log, written only by the monitor
  req_t seen   [2][64];
  int   seen_n [2] = '{0, 0};
  int   rd_hs  [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst[i] && mem_req_valid[i] && mem_req_ready[i]) begin
        if (seen_n[i] < 64)
          seen[i][seen_n[i]] = '{mem_req_we[i], mem_req_addr[i],
                                 mem_req_we[i] ? mem_req_wdata[i] : 32'd0};
        seen_n[i] = seen_n[i] + 1;
        if (!mem_req_we[i]) rd_hs[i] = rd_hs[i] + 1;
      end
    end
  end

  // Memory response model
  logic        auto_rsp = 1'b1;
  logic        force_rsp [2] = '{1'b0, 1'b0};
  logic [31:0] rsp_val   [2] = '{32'd0, 32'd0};
  int          rsp_done  [2] = '{0, 0};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_rdata[i] = rsp_val[i];
      if (rd_hs[i] != rsp_done[i]) begin
        rsp_done[i]      = rd_hs[i];
        mem_rsp_valid[i] = auto_rsp;
      end else begin
        mem_rsp_valid[i] = force_rsp[i];
      end
    end
  end

  int   errors = 0;
  int   checks = 0;
  req_t exp_q[$];
  int   rd_idx [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_mem(input int inst, input string name);
    req_t e;
    req_t a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx[inst] >= seen_n[inst]) begin
        errors++;
        $display("FAIL %s: missing request, expected we=%0b addr=%h data=%h",
                 name, e.we, e.addr, e.data);
      end else begin
        a = seen[inst][rd_idx[inst]];
        rd_idx[inst]++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: request got we=%0b addr=%h data=%h, expected we=%0b addr=%h data=%h",
                   name, a.we, a.addr, a.data, e.we, e.addr, e.data);
        end
      end
    end
    checks++;
    if (rd_idx[inst] != seen_n[inst]) begin
      errors++;
      $display("FAIL %s_extra: got %0d requests, expected %0d", name, seen_n[inst], rd_idx[inst]);
      rd_idx[inst] = seen_n[inst];
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic plot(input int inst, input int x, input int y, input logic [7:0] c,
                      input logic [1:0] m, output int waits);
    waits          = 0;
    in_x[inst]     = 16'(x);
    in_y[inst]     = 16'(y);
    in_color[inst] = c;
    in_mode[inst]  = m;
    in_valid[inst] = 1'b1;
    @(negedge clk);
    while (!in_ready[inst] && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) begin
      checks++;
      errors++;
      $display("FAIL plot_timeout: in_ready low for %0d cycles, expected acceptance", waits);
    end
    @(posedge clk); #1;
    in_valid[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready[inst] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready[inst], n);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_flush(input int inst, output int pulses);
    wait_idle(inst);
    pulses          = 0;
    flush_req[inst] = 1'b1;
    @(posedge clk); #1;
    flush_req[inst] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (flush_done[inst]) pulses++;
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs [9];
  int   w;
  int   p;
  logic [15:0] pc_before;

  initial begin
    vecs[0] = '{5,  3,  8'h01, 2'b00, 32'h00000000, 1'b0, 32'h2018, 32'h00000020};
    vecs[1] = '{-1, 5,  8'h01, 2'b00, 32'h00000000, 1'b1, 32'h0,    32'h0};
    vecs[2] = '{64, 0,  8'h01, 2'b00, 32'h00000000, 1'b1, 32'h0,    32'h0};
    vecs[3] = '{0,  64, 8'h01, 2'b00, 32'h00000000, 1'b1, 32'h0,    32'h0};
    vecs[4] = '{63, 63, 8'h00, 2'b01, 32'hFFFFFFFF, 1'b0, 32'h21FC, 32'h7FFFFFFF};
    vecs[5] = '{33, 0,  8'h01, 2'b10, 32'h00000002, 1'b0, 32'h2004, 32'h00000000};
    vecs[6] = '{7,  10, 8'h01, 2'b11, 32'hFFFFFFFF, 1'b0, 32'h2050, 32'hFFFFFF7F};
    vecs[7] = '{0,  -1, 8'h01, 2'b00, 32'h00000000, 1'b1, 32'h0,    32'h0};
    vecs[8] = '{2,  1,  8'hFE, 2'b00, 32'h00000001, 1'b0, 32'h2008, 32'h00000001};

    for (int i = 0; i < 2; i++) begin
      rst[i]           = 1'b1;
      in_valid[i]      = 1'b0;
      in_x[i]          = '0;
      in_y[i]          = '0;
      in_color[i]      = '0;
      in_mode[i]       = '0;
      flush_req[i]     = 1'b0;
      mem_req_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",   32'(in_ready[0]),      32'd1);
    chk("rst_req_valid",  32'(mem_req_valid[0]), 32'd0);
    chk("rst_req_we",     32'(mem_req_we[0]),    32'd0);
    chk("rst_req_addr",   mem_req_addr[0],       32'd0);
    chk("rst_req_wdata",  mem_req_wdata[0],      32'd0);
    chk("rst_busy",       32'(busy[0]),          32'd0);
    chk("rst_flush_done", 32'(flush_done[0]),    32'd0);
    chk("rst_plot_count", 32'(plot_count[0]),    32'd0);
    chk("rst_clip_count", 32'(clip_count[0]),    32'd0);
    chk("rst_in_ready1",  32'(in_ready[1]),      32'd1);
    @(posedge clk); #1;

    // Table: single pixel from an empty buffer, then flush
    for (int i = 0; i < 9; i++) begin
      rsp_val[0] = vecs[i].rd;
      if (!vecs[i].clip) begin
        exp_q.push_back('{1'b0, vecs[i].addr, 32'd0});
        exp_q.push_back('{1'b1, vecs[i].addr, vecs[i].wdata});
      end
      plot(0, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].m, w);
      if (vecs[i].clip) chk($sformatf("vec%0d_clip_in_ready_waits", i), 32'(w), 32'd0);
      do_flush(0, p);
      chk($sformatf("vec%0d_flush_done_pulses", i), 32'(p), 32'd1);
      compare_mem(0, $sformatf("vec%0d_mem", i));
    end
    chk("table_plot_count", 32'(plot_count[0]), 32'd5);
    chk("table_clip_count", 32'(clip_count[0]), 32'd4);
    chk("table_busy",       32'(busy[0]),       32'd0);

    // Three pixels in one word: one read, combined write
    rsp_val[0] = 32'd0;
    exp_q.push_back('{1'b0, 32'h2000, 32'd0});
    exp_q.push_back('{1'b1, 32'h2000, 32'h80000003});
    plot(0, 0, 0, 8'h01, 2'b00, w);
    plot(0, 1, 0, 8'h01, 2'b00, w);
    plot(0, 31, 0, 8'h01, 2'b00, w);
    chk("combine_hit_waits", 32'(w), 32'd0);
    chk("combine_busy_dirty", 32'(busy[0]), 32'd1);
    do_flush(0, p);
    chk("combine_flush_done", 32'(p), 32'd1);
    compare_mem(0, "combine_mem");
    chk("combine_plot_count", 32'(plot_count[0]), 32'd8);

    // Miss on a dirty buffer: write-back precedes the read, held under stall
    exp_q.push_back('{1'b0, 32'h2000, 32'd0});
    exp_q.push_back('{1'b1, 32'h2000, 32'h00000001});
    exp_q.push_back('{1'b0, 32'h2004, 32'd0});
    exp_q.push_back('{1'b1, 32'h2004, 32'h00000001});
    plot(0, 0, 0, 8'h01, 2'b00, w);
    wait_idle(0);
    mem_req_ready[0] = 1'b0;
    plot(0, 32, 0, 8'h01, 2'b00, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(mem_req_valid[0]), 32'd1);
      chk("stall_req_we",    32'(mem_req_we[0]),    32'd1);
      chk("stall_req_addr",  mem_req_addr[0],       32'h2000);
      chk("stall_req_wdata", mem_req_wdata[0],      32'h00000001);
    end
    @(posedge clk); #1;
    mem_req_ready[0] = 1'b1;
    do_flush(0, p);
    chk("evict_flush_done", 32'(p), 32'd1);
    compare_mem(0, "evict_mem");
    chk("evict_plot_count", 32'(plot_count[0]), 32'd10);

    // Flush and pixel together: flush wins, pixel not taken
    pc_before      = plot_count[0];
    in_x[0]        = 16'sd3;
    in_y[0]        = 16'sd3;
    in_color[0]    = 8'h01;
    in_mode[0]     = 2'b00;
    in_valid[0]    = 1'b1;
    flush_req[0]   = 1'b1;
    @(negedge clk);
    chk("flush_wins_in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    flush_req[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_wins_plot_count", 32'(plot_count[0]), 32'(pc_before));
    compare_mem(0, "flush_wins_mem");

    // BPP=4 XOR
    rsp_val[1] = 32'h000000F0;
    exp_q.push_back('{1'b0, 32'h2044, 32'd0});
    exp_q.push_back('{1'b1, 32'h2044, 32'h000000A0});
    plot(1, 9, 2, 8'h05, 2'b10, w);
    do_flush(1, p);
    chk("bpp4_flush_done", 32'(p), 32'd1);
    compare_mem(1, "bpp4_mem");
    chk("bpp4_plot_count", 32'(plot_count[1]), 32'd1);

    // Reset while waiting for a read response
    auto_rsp = 1'b0;
    exp_q.push_back('{1'b0, 32'h2020, 32'd0});
    plot(0, 4, 4, 8'h01, 2'b00, w);
    @(posedge clk); #1;
    chk("rwait_busy", 32'(busy[0]), 32'd1);
    rst[0] = 1'b1;
    #1;
    chk("async_rst_req_valid", 32'(mem_req_valid[0]), 32'd0);
    chk("async_rst_busy",      32'(busy[0]),          32'd0);
    chk("async_rst_plot",      32'(plot_count[0]),    32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    force_rsp[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force_rsp[0] = 1'b0;
    auto_rsp = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("late_rsp_in_ready",   32'(in_ready[0]),   32'd1);
    chk("late_rsp_busy",       32'(busy[0]),       32'd0);
    chk("late_rsp_plot_count", 32'(plot_count[0]), 32'd0);
    chk("late_rsp_clip_count", 32'(clip_count[0]), 32'd0);
    do_flush(0, p);
    chk("post_rst_flush_done", 32'(p), 32'd1);
    compare_mem(0, "post_rst_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_pixel_plotter.md
# fb_pixel_plotter

Hardware pixel plotter for the SM-side framebuffer: accepts clipped-or-not screen coordinates with a colour and raster op, performs the word read-modify-write that shader code currently does in software (SHL/SHR/AND/LDR/OR/STR), and issues it on a simple request/response memory port. It is generalised over framebuffer size, bits per pixel and raster op. A one-word write-combining buffer merges consecutive pixels that fall in the same 32-bit word, which removes redundant reads. It sits between the SM store path and the data memory, ahead of the frame capture logic.

## Interface
Parameters:
- FB_WIDTH, 64, pixels per row; must be a multiple of 32/BPP
- FB_HEIGHT, 64, rows
- BPP, 1, bits per pixel; legal values are 1, 2, 4, 8
- FB_BASE, 32'h2000, byte address of pixel (0,0); 4-byte aligned
- COORD_W, 16, signed coordinate width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous assert, active-high
- in_valid  in  1  pixel command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_x, in_y  in  COORD_W  signed pixel coordinates
- in_color  in  8  colour; low BPP bits are used
- in_mode  in  2  raster op: 00 OR, 01 REPLACE, 10 XOR, 11 CLEAR
- flush_req  in  1  write back the dirty buffer and invalidate it
- flush_done  out  1  one-cycle pulse when the flush completes
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  32  word-aligned byte address
- mem_req_wdata  out  32  write data
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  32  read data
- busy  out  1  state is not IDLE, or the buffer is dirty
- plot_count  out  16  pixels plotted; saturates at 0xFFFF
- clip_count  out  16  pixels dropped by clipping; saturates at 0xFFFF

## Operation
- Address calculation, with PPW = 32/BPP and WPR = FB_WIDTH/PPW:
  - addr = FB_BASE + 4*(y*WPR + x/PPW)
  - bit shift = (x%PPW)*BPP
  - Pixel 0 of each word is in the LSBs. For BPP=1 and 64x64 this gives the existing layout: 8 bytes per row, bit x%32.
- Clip: a pixel with x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT is consumed, increments clip_count and generates no memory traffic.
- Raster op on the BPP-wide field f, with c = in_color[BPP-1:0]:
  - OR: f|c
  - REPLACE: c
  - XOR: f^c
  - CLEAR: 0
- Buffer registers: buf_valid, buf_dirty, buf_addr, buf_data. Every op sets buf_dirty, including ops that leave the data unchanged.
- States are IDLE, WB, RD, RWAIT.
- IDLE, on an accepted in-range pixel:
  - Hit (buf_valid and addr == buf_addr): apply the op to buf_data; the result is registered at the next edge. Stay in IDLE.
  - Miss: latch the pixel. Go to WB if buf_dirty, otherwise to RD.
- WB:
  - Drive mem_req_valid=1, we=1, addr=buf_addr, wdata=buf_data.
  - When mem_req_ready is seen, clear buf_dirty. Go to RD for a miss, or to IDLE for a flush (and pulse flush_done there).
- RD: drive mem_req_valid=1, we=0, addr=latched addr. When mem_req_ready is seen, go to RWAIT.
- RWAIT: on mem_rsp_valid, set buf_data = op(rdata), buf_addr = addr, buf_valid=1, buf_dirty=1. Go to IDLE.
- flush_req sampled in IDLE:
  - Dirty buffer: go to WB, then to IDLE. flush_done pulses on the cycle the write handshake completes.
  - Clean buffer: flush_done pulses on the next cycle.
  - In both cases buf_valid is cleared, so later external memory writes are visible.
- plot_count increments once per in-range pixel, at hit-update time or at RWAIT completion.

## Timing
- in_ready = (state==IDLE) && !flush_req. Hits and clipped pixels sustain 1 pixel per cycle.
- Miss latency, from acceptance to in_ready: 1 cycle to leave IDLE, plus any WB handshake, plus the RD handshake, plus response latency, plus 1 cycle.
- mem_req_valid is asserted only in WB and RD. Address, data and we stay stable until mem_req_ready is seen.
- mem_rsp_valid outside RWAIT is ignored.
- If flush_req and in_valid are both high in IDLE, the flush wins and the pixel is not accepted.
- Reset values: state=IDLE; in_ready=1 after reset release; buf_valid=0 and buf_dirty=0; mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0; flush_done=0; busy=0; both counters=0.
- Reset in any state, including mid-handshake, discards dirty data without a write. A response arriving after reset is ignored.

## Test plan
All scenarios use 64x64 and FB_BASE=0x2000.
- BPP=1, OR of (5,3), memory returns 0, then flush -> read of 0x2018, then write of 0x2018 with data 0x00000020; flush_done pulses once; plot_count=1.
- BPP=1, OR of (0,0), (1,0), (31,0) back-to-back, then flush -> exactly one read of 0x2000; in_ready is high on every cycle after the fill; one write of 0x2000 with data 0x80000003.
- BPP=1, (0,0) then (32,0) -> write of 0x2000 with data 0x00000001 precedes the read of 0x2004.
- Pixels (-1,5), (64,0), (0,64) -> no memory requests; clip_count=3; in_ready stays high throughout.
- BPP=4, XOR of (9,2) with colour 0x5, memory returns 0x000000F0, then flush -> read and write of 0x2044; write data 0x000000A0.
- Assert rst while in RWAIT, then deliver a late response -> mem_req_valid=0 immediately; after release, counters=0, busy=0, and no write is issued.
